// File: rtl/rf_alu_seq.sv
// Serial register-register ALU sequencer in front of a 2R1W register file.
// Walks IDLE -> RD -> EX -> WB, so one instruction issues every four cycles.
module rf_alu_seq #(
  parameter int BW_DATA  = 32,
  parameter int BW_ADDR  = 5,
  parameter int ZERO_REG = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2:0]         i_op,
  input  logic [BW_ADDR-1:0] i_rd,
  input  logic [BW_ADDR-1:0] i_rs0,
  input  logic [BW_ADDR-1:0] i_rs1,
  output logic [BW_ADDR-1:0] o_rf_rd_addr0,
  output logic [BW_ADDR-1:0] o_rf_rd_addr1,
  input  logic [BW_DATA-1:0] i_rf_rd_data0,
  input  logic [BW_DATA-1:0] i_rf_rd_data1,
  output logic [BW_DATA-1:0] o_rf_wr_data,
  output logic [BW_ADDR-1:0] o_rf_wr_addr,
  output logic               o_rf_wr_en,
  output logic               o_done,
  output logic               o_ovf
);

  localparam int SW  = $clog2(BW_DATA);
  localparam int MSB = BW_DATA - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]         op_q;
  logic [BW_ADDR-1:0] rd_q, rs0_q, rs1_q;
  logic [BW_DATA-1:0] op_a, op_b, result;

  logic [BW_DATA-1:0] alu_res;
  logic               alu_ovf;
  logic [BW_DATA-1:0] sum, diff;
  logic [SW-1:0]      sh;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_valid) state_nxt = S_RD;
      S_RD:    state_nxt = S_EX;
      S_EX:    state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    sh      = op_b[SW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {{(BW_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SHL:  alu_res = op_a << sh;
      OP_SHR:  alu_res = op_a >> sh;
      default: alu_res = '0;
    endcase
  end

  // o_ovf is updated together with result so it is valid in the WB cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q   <= '0;
      rd_q   <= '0;
      rs0_q  <= '0;
      rs1_q  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (state == S_IDLE && i_valid) begin
        op_q  <= i_op;
        rd_q  <= i_rd;
        rs0_q <= i_rs0;
        rs1_q <= i_rs1;
      end
      if (state == S_RD) begin
        op_a <= i_rf_rd_data0;
        op_b <= i_rf_rd_data1;
      end
      if (state == S_EX) begin
        result <= alu_res;
        o_ovf  <= alu_ovf;
      end
    end
  end

  always_comb begin
    o_ready       = 1'b0;
    o_rf_rd_addr0 = '0;
    o_rf_rd_addr1 = '0;
    o_rf_wr_addr  = '0;
    o_rf_wr_data  = '0;
    o_rf_wr_en    = 1'b0;
    o_done        = 1'b0;
    case (state)
      S_IDLE: o_ready = 1'b1;
      S_RD: begin
        o_rf_rd_addr0 = rs0_q;
        o_rf_rd_addr1 = rs1_q;
      end
      S_WB: begin
        o_rf_wr_addr = rd_q;
        o_rf_wr_data = result;
        o_rf_wr_en   = !((ZERO_REG != 0) && (rd_q == '0));
        o_done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_alu_seq.sv
// Directed bench for rf_alu_seq: behavioural register file, vector table,
// plus hand sequences for back-to-back issue and reset mid-instruction.
module tb_rf_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [2:0]  op = '0;
  logic [4:0]  rd = '0, rs0 = '0, rs1 = '0;

  logic        ready, wr_en, done, ovf;
  logic [4:0]  rd_addr0, rd_addr1, wr_addr;
  logic [31:0] rd_data0, rd_data1, wr_data;

  logic        ready_z, wr_en_z, done_z, ovf_z;
  logic [4:0]  rd_addr0_z, rd_addr1_z, wr_addr_z;
  logic [31:0] rd_data0_z, rd_data1_z, wr_data_z;

  logic [31:0] rf [32];
  logic        rf_clr = 1'b1;
  logic        pre_en = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_alu_seq #(.BW_DATA(32), .BW_ADDR(5), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_op(op), .i_rd(rd), .i_rs0(rs0), .i_rs1(rs1),
    .o_rf_rd_addr0(rd_addr0), .o_rf_rd_addr1(rd_addr1),
    .i_rf_rd_data0(rd_data0), .i_rf_rd_data1(rd_data1),
    .o_rf_wr_data(wr_data), .o_rf_wr_addr(wr_addr), .o_rf_wr_en(wr_en),
    .o_done(done), .o_ovf(ovf)
  );

  // r0-writable variant runs in lockstep; its writes do not reach the model
  rf_alu_seq #(.BW_DATA(32), .BW_ADDR(5), .ZERO_REG(0)) dut_z (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_z),
    .i_op(op), .i_rd(rd), .i_rs0(rs0), .i_rs1(rs1),
    .o_rf_rd_addr0(rd_addr0_z), .o_rf_rd_addr1(rd_addr1_z),
    .i_rf_rd_data0(rd_data0_z), .i_rf_rd_data1(rd_data1_z),
    .o_rf_wr_data(wr_data_z), .o_rf_wr_addr(wr_addr_z), .o_rf_wr_en(wr_en_z),
    .o_done(done_z), .o_ovf(ovf_z)
  );

  assign rd_data0   = rf[rd_addr0];
  assign rd_data1   = rf[rd_addr1];
  assign rd_data0_z = rf[rd_addr0_z];
  assign rd_data1_z = rf[rd_addr1_z];

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (pre_en) begin
      rf[pre_addr] <= pre_data;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  typedef struct {
    logic [4:0]  pa;
    logic [31:0] pa_val;
    logic [4:0]  pb;
    logic [31:0] pb_val;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic        exp_wen;
    logic        exp_wen_z;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Drive one instruction at a negedge; returns right after the accept edge + #1
  task automatic issue(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s0,
                       input logic [4:0] s1);
    @(negedge clk);
    check("ready_before_issue", {31'b0, ready}, 32'd1);
    valid = 1'b1; op = o; rd = d; rs0 = s0; rs1 = s1;
    @(posedge clk); #1;
    valid = 1'b0; op = '0; rd = '0; rs0 = '0; rs1 = '0;
  endtask

  task automatic run_vec(input vec_t v);
    preload(v.pa, v.pa_val);
    preload(v.pb, v.pb_val);
    issue(v.op, v.rd, v.rs0, v.rs1);
    check("ready_in_rd", {31'b0, ready}, 32'd0);
    check("rd_addr0", {27'b0, rd_addr0}, {27'b0, v.rs0});
    check("rd_addr1", {27'b0, rd_addr1}, {27'b0, v.rs1});
    @(posedge clk); #1;
    check("wr_en_in_ex", {31'b0, wr_en}, 32'd0);
    check("rd_addr0_in_ex", {27'b0, rd_addr0}, 32'd0);
    @(posedge clk); #1;
    check("done", {31'b0, done}, 32'd1);
    check("wr_en", {31'b0, wr_en}, {31'b0, v.exp_wen});
    check("wr_en_z", {31'b0, wr_en_z}, {31'b0, v.exp_wen_z});
    check("wr_addr", {27'b0, wr_addr}, {27'b0, v.rd});
    check("wr_addr_z", {27'b0, wr_addr_z}, {27'b0, v.rd});
    check("wr_data", wr_data, v.exp_data);
    check("ovf", {31'b0, ovf}, {31'b0, v.exp_ovf});
    @(posedge clk); #1;
    check("ready_after", {31'b0, ready}, 32'd1);
    check("done_after", {31'b0, done}, 32'd0);
    check("wr_data_idle", wr_data, 32'd0);
    if (v.exp_wen) check("rf_written", rf[v.rd], v.exp_data);
    else           check("rf_r0_kept", rf[v.rd], 32'd0);
  endtask

  int acc [2];
  int na, nw;
  logic [31:0] wd [2];

  initial begin
    vecs[0]  = '{5'd1, 32'd5,          5'd2,  32'd7,          3'd0, 5'd3,  5'd1, 5'd2,  32'd12,         1'b0, 1'b1, 1'b1};
    vecs[1]  = '{5'd1, 32'h7FFF_FFFF,  5'd2,  32'd1,          3'd0, 5'd4,  5'd1, 5'd2,  32'h8000_0000,  1'b1, 1'b1, 1'b1};
    vecs[2]  = '{5'd1, 32'h7FFF_FFFF,  5'd2,  32'd1,          3'd1, 5'd5,  5'd2, 5'd1,  32'h8000_0002,  1'b0, 1'b1, 1'b1};
    vecs[3]  = '{5'd1, 32'hFFFF_FFFF,  5'd2,  32'd1,          3'd5, 5'd7,  5'd1, 5'd2,  32'd1,          1'b0, 1'b1, 1'b1};
    vecs[4]  = '{5'd1, 32'd1,          5'd2,  32'hFFFF_FFFF,  3'd5, 5'd16, 5'd1, 5'd2,  32'd0,          1'b0, 1'b1, 1'b1};
    vecs[5]  = '{5'd6, 32'h21,         5'd2,  32'd1,          3'd6, 5'd8,  5'd2, 5'd6,  32'd2,          1'b0, 1'b1, 1'b1};
    vecs[6]  = '{5'd9, 32'h8000_0000,  5'd10, 32'd31,         3'd7, 5'd11, 5'd9, 5'd10, 32'd1,          1'b0, 1'b1, 1'b1};
    vecs[7]  = '{5'd1, 32'hF0F0,       5'd2,  32'hFF00,       3'd2, 5'd12, 5'd1, 5'd2,  32'hF000,       1'b0, 1'b1, 1'b1};
    vecs[8]  = '{5'd1, 32'hF0F0,       5'd2,  32'hFF00,       3'd3, 5'd13, 5'd1, 5'd2,  32'hFFF0,       1'b0, 1'b1, 1'b1};
    vecs[9]  = '{5'd1, 32'hF0F0,       5'd2,  32'hFF00,       3'd4, 5'd14, 5'd1, 5'd2,  32'h0FF0,       1'b0, 1'b1, 1'b1};
    vecs[10] = '{5'd1, 32'h8000_0000,  5'd2,  32'd1,          3'd1, 5'd15, 5'd1, 5'd2,  32'h7FFF_FFFF,  1'b1, 1'b1, 1'b1};
    vecs[11] = '{5'd1, 32'd3,          5'd2,  32'd4,          3'd0, 5'd0,  5'd1, 5'd2,  32'd7,          1'b0, 1'b0, 1'b1};

    // Reset state, sampled while reset is still held
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_rd_addr0", {27'b0, rd_addr0}, 32'd0);
    check("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    @(negedge clk);
    rst = 1'b0; rf_clr = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Back-to-back: valid held high, r3 = r3 + r3 twice from r3 = 1
    preload(5'd3, 32'd1);
    na = 0; nw = 0;
    @(negedge clk);
    valid = 1'b1; op = 3'd0; rd = 5'd3; rs0 = 5'd3; rs1 = 5'd3;
    for (int c = 0; c < 16; c++) begin
      if (ready && valid && na < 2) begin
        acc[na] = c;
        na++;
      end
      if (wr_en && nw < 2) begin
        wd[nw] = wr_data;
        nw++;
      end
      @(posedge clk);
      if (na == 2) begin
        #1 valid = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    check("b2b_accepts", na, 2);
    check("b2b_writes", nw, 2);
    if (na == 2) check("b2b_gap", acc[1] - acc[0], 4);
    if (nw == 2) begin
      check("b2b_wd0", wd[0], 32'd2);
      check("b2b_wd1", wd[1], 32'd4);
    end
    check("b2b_rf3", rf[3], 32'd4);

    // Reset during EX after an overflowing ADD left ovf=1
    run_vec(vecs[1]);
    issue(3'd0, 5'd21, 5'd1, 5'd2);
    @(posedge clk); #1;
    check("ex_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("ex_rst_ready", {31'b0, ready}, 32'd1);
    check("ex_rst_ovf", {31'b0, ovf}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("ex_rst_wr_en", {31'b0, wr_en}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ex_rst_no_write", rf[21], 32'd0);
    check("ex_rst_idle", {31'b0, ready}, 32'd1);
    run_vec(vecs[0]);

    // Reset asserted in WB drops wr_en without waiting for a clock
    issue(3'd0, 5'd22, 5'd1, 5'd2);
    repeat (2) @(posedge clk);
    #1;
    check("wb_wr_en", {31'b0, wr_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("wb_rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("wb_rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    check("wb_rst_no_write", rf[22], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
